lab2_proc_multi_drop_unit: RTL
==============================

# lab2_proc_multi_drop_unit

Parametrised in-flight tracking and response-drop unit for the fetch path. It sits between the instruction-memory response stream and the F stage. It counts outstanding memory requests up to `p_max_inflight`, throttles further issue when that limit is reached, and on a squash silently consumes every response belonging to requests already in flight. This generalises the single-response drop behaviour to arbitrary request-queue depth and message width, so a deeper fetch queue can be squashed in one cycle.

## Interface
- `p_msg_nbits`, 47: response message width (`$bits(mem_resp_4B_t)`).
- `p_max_inflight`, 2: maximum outstanding requests (≥1).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `squash`  in  1  redirect: every response for an already-issued request is to be dropped.
- `req_xfer`  in  1  a request was accepted by the request queue this cycle.
- `issue_ok`  out  1  further requests may be issued (`inflight < p_max_inflight`).
- `istream_msg`  in  p_msg_nbits  response from memory.
- `istream_val`  in  1  response valid.
- `istream_rdy`  out  1  response accepted.
- `ostream_msg`  out  p_msg_nbits  response to F stage (wire copy of `istream_msg`).
- `ostream_val`  out  1  forwarded response valid.
- `ostream_rdy`  in  1  F stage ready.
- `num_inflight`  out  CW  current outstanding count, where CW = `$clog2(p_max_inflight+1)`.
- `num_to_drop`  out  CW  responses still to be dropped.
- `num_dropped`  out  32  total dropped responses. Present only with `LAB2_PROC_MULTI_DROP_STATS_EN`.

## Operation
- Registers: `inflight` (CW bits), `drop_cnt` (CW bits). Invariant: `drop_cnt ≤ inflight ≤ p_max_inflight`.
- Mode is derived, not separately stored:
  - PASS when `drop_cnt == 0`.
  - DROP when `drop_cnt > 0`.
- Dropping condition: `dropping = squash || (drop_cnt != 0)`.
- PASS and not squashing:
  - `ostream_val = istream_val`
  - `istream_rdy = ostream_rdy`
- Dropping:
  - `ostream_val = 0`
  - `istream_rdy = 1`
  - Any presented response is consumed and discarded.
- `resp_fire = istream_val && istream_rdy`.
- `inflight_next = inflight + req_xfer − resp_fire`.
- `drop_cnt` update:
  - If `squash`: `drop_next = inflight − resp_fire`. A request issued in the same cycle as the squash belongs to the new path and is never dropped.
  - Else if `drop_cnt != 0`: `drop_next = drop_cnt − resp_fire`.
  - Else: `drop_cnt` holds.
- A squash while already in DROP recomputes `drop_cnt` from `inflight`. Repeated squashes are idempotent.
- `req_xfer` while `issue_ok == 0` is a protocol violation: `inflight` saturates at `p_max_inflight`.
- `istream_val` while `inflight == 0` is a protocol violation: `inflight` and `drop_cnt` saturate at 0.

## Timing
- Data path is combinational, with zero latency from `istream` to `ostream`.
- Squash takes effect in the same cycle for any response presented that cycle.
- Counter updates become visible the cycle after the triggering event.
- `issue_ok` is a registered function of `inflight`. It does not count a same-cycle response; the one-cycle conservatism is accepted.
- Reset (async, `reset == 0`):
  - `inflight = 0`, `drop_cnt = 0`, `num_dropped = 0`.
  - While reset is held: `istream_rdy = 0`, `ostream_val = 0`, `issue_ok = 0`.
- Deassertion is synchronised externally. The first active edge after deassertion sees clean zero state.
- Reset mid-drop abandons the pending drops. Any stale in-flight responses are the memory system's responsibility, since memory is reset with the processor.

## Configuration
- `LAB2_PROC_MULTI_DROP_STATS_EN` defined:
  - Adds the `num_dropped` port and its 32-bit wrapping counter, which increments on each `resp_fire` while `dropping`.
  - Adds simulation-only assertions for both protocol violations, which abort with an `$error`.
- Undefined: no `num_dropped` port, no counter, no assertions. Core behaviour is identical either way.

## Structure
- Shared package `lab2_proc_fetch_pkg` holds:
  - the `mem_resp_4B_t` width constant;
  - the CW computation as a function `inflight_nbits(max)`.
- One natural sub-module, `lab2_proc_sat_updown_counter`: a CW-bit up/down counter with load, saturating at 0 and at the maximum. It is instantiated twice, for `inflight` and `drop_cnt`.
- Pass/drop muxing and the stats counter live in the top module.

## Test plan
- Pass-through: issue 2 requests, return 2 responses with data 0x11/0x22 and `ostream_rdy = 1`. Expect both forwarded in order, `num_inflight` to go 2→0, and `issue_ok` to go 0→1.
- Squash with 2 outstanding and no response that cycle. Expect `num_to_drop = 2` next cycle, the next 2 responses consumed with `ostream_val = 0`, then a third, post-squash response forwarded.
- Squash coinciding with a response and with `req_xfer`, with `inflight = 2`. Expect the same-cycle response dropped, `num_to_drop = 1`, `num_inflight = 2`, and exactly one further drop.
- Backpressure: PASS with `ostream_rdy = 0` for 3 cycles. Expect `istream_rdy = 0` and counters held. During DROP, expect `istream_rdy = 1` regardless of `ostream_rdy`.
- Configuration with `p_max_inflight = 4`, `p_msg_nbits = 64`. Issue 4 requests, expect `issue_ok = 0`. Double squash in consecutive cycles: expect `num_to_drop` to stay 4, with stats build showing `num_dropped = 4` after drain.
- Reset asserted mid-drop with `drop_cnt = 1`. Expect all outputs to go to reset values immediately (async). After release, the first response is forwarded.

Source files
------------

// File: rtl/lab2_proc_multi_drop_unit_pkg.sv
// Shared fetch-path types: memory response layout and in-flight counter width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lab2_proc_fetch_pkg;

    // 4-byte memory response as carried on the fetch response stream.
    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    localparam int MEM_RESP_4B_NBITS = $bits(mem_resp_4B_t);

    // Counter width able to hold every value 0..max inclusive.
    function automatic int inflight_nbits(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/lab2_proc_multi_drop_unit_if.sv
// Valid/ready message stream bundle used for the memory response and F-stage streams.
// Latency: n/a (wires only).
// Backpressure: producer holds msg/val until rdy is seen high.
// Ports: msg, val (producer -> consumer); rdy (consumer -> producer).
interface lab2_proc_multi_drop_unit_if #(
    parameter int p_msg_nbits = 47
);
    logic [p_msg_nbits-1:0] msg;
    logic                   val;
    logic                   rdy;

    modport master (output msg, output val, input rdy);
    modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/lab2_proc_multi_drop_unit_counter.sv
// Saturating up/down counter with load, clamped to the range 0..p_max.
// Latency: new value visible one cycle after ld/up/dn.
// Backpressure: none; an up at p_max or a down at 0 is absorbed by saturation.
// Ports: clk, reset (async active-low), ld/ld_val, up, dn, cnt.
module lab2_proc_sat_updown_counter #(
    parameter int p_nbits = 2,
    parameter int p_max   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld,
    input  logic [p_nbits-1:0] ld_val,
    input  logic               up,
    input  logic               dn,
    output logic [p_nbits-1:0] cnt
);
    localparam logic [p_nbits-1:0] MAX = p_nbits'(p_max);
    localparam logic [p_nbits-1:0] ONE = p_nbits'(1);

    logic [p_nbits-1:0] cnt_q;
    logic [p_nbits-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = (ld_val > MAX) ? MAX : ld_val;
        end else if (up && !dn) begin
            if (cnt_q < MAX) cnt_d = cnt_q + ONE;
        end else if (dn && !up) begin
            if (cnt_q != '0) cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/lab2_proc_multi_drop_unit.sv
// In-flight request tracker and squash response dropper between imem responses and F stage.
// Latency: zero-cycle combinational response path; counters update on the next edge.
// Backpressure: PASS forwards ostream.rdy to istream; while dropping istream.rdy is forced high.
// Ports: clk, reset (async active-low), squash, req_xfer, issue_ok, istream (slave),
//        ostream (master), num_inflight, num_to_drop, num_dropped (stats build only).
// Optional macro LAB2_PROC_MULTI_DROP_STATS_EN adds num_dropped and protocol assertions.
module lab2_proc_multi_drop_unit
    import lab2_proc_fetch_pkg::*;
#(
    parameter  int p_msg_nbits    = MEM_RESP_4B_NBITS,
    parameter  int p_max_inflight = 2,
    localparam int CW             = inflight_nbits(p_max_inflight)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         squash,
    input  logic                         req_xfer,
    output logic                         issue_ok,
    lab2_proc_multi_drop_unit_if.slave   istream,
    lab2_proc_multi_drop_unit_if.master  ostream,
    output logic [CW-1:0]                num_inflight,
    output logic [CW-1:0]                num_to_drop
`ifdef LAB2_PROC_MULTI_DROP_STATS_EN
    ,
    output logic [31:0]                  num_dropped
`endif
);
    localparam logic [CW-1:0] MAX = CW'(p_max_inflight);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0]          inflight;
    logic [CW-1:0]          drop_cnt;
    logic [CW-1:0]          drop_ld_val;
    logic                   drop_active;
    logic                   dropping;
    logic                   resp_fire;
    logic [p_msg_nbits-1:0] resp_msg;

    assign drop_active = (drop_cnt != '0);
    // A squash drops this cycle's response immediately, before drop_cnt is loaded.
    assign dropping    = squash || drop_active;

    // Reset gating keeps both handshakes idle while reset is held.
    assign istream.rdy = reset && (dropping ? 1'b1 : ostream.rdy);
    assign ostream.val = reset && !dropping && istream.val;
    assign resp_msg    = istream.msg;
    assign ostream.msg = resp_msg;

    assign resp_fire   = istream.val && istream.rdy;
    assign issue_ok    = reset && (inflight < MAX);

    // Everything already issued is dropped, less one if its response is consumed now.
    // A same-cycle req_xfer belongs to the new path and is deliberately not counted.
    assign drop_ld_val = (resp_fire && inflight != '0) ? (inflight - ONE) : inflight;

    lab2_proc_sat_updown_counter #(
        .p_nbits (CW),
        .p_max   (p_max_inflight)
    ) u_inflight (
        .clk    (clk),
        .reset  (reset),
        .ld     (1'b0),
        .ld_val ('0),
        .up     (req_xfer),
        .dn     (resp_fire),
        .cnt    (inflight)
    );

    lab2_proc_sat_updown_counter #(
        .p_nbits (CW),
        .p_max   (p_max_inflight)
    ) u_drop_cnt (
        .clk    (clk),
        .reset  (reset),
        .ld     (squash),
        .ld_val (drop_ld_val),
        .up     (1'b0),
        .dn     (resp_fire && drop_active),
        .cnt    (drop_cnt)
    );

    assign num_inflight = inflight;
    assign num_to_drop  = drop_cnt;

`ifdef LAB2_PROC_MULTI_DROP_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    num_dropped <= '0;
        else if (resp_fire && dropping) num_dropped <= num_dropped + 32'd1;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset) begin
            assert (!(req_xfer && !issue_ok))
                else $error("req_xfer while issue_ok is low");
            assert (!(istream.val && inflight == '0))
                else $error("istream_val with no request in flight");
        end
    end
`endif
`endif
endmodule
